// File: rtl/path_decoder.sv
// Path decoder: pops stored locations one at a time from an upstream path
// store and turns each pair of neighbouring locations into a 2-bit move code
// (00 up / Y-1, 01 right / X+1, 10 down / Y+1, 11 left / X-1), handed to a
// downstream consumer over a valid/ready handshake.
//
// A location word carries X in its upper COORD_W bits and Y in its lower
// COORD_W bits. Two locations are adjacent only if exactly one coordinate
// differs by exactly one, with no wrap-around at the grid edge. A repeated
// location, a non-adjacent step, or one move more than MAX_STEPS ends the
// decode with err; draining the store cleanly ends it with finished.
//
// Handshake with the store: pop is a one-cycle request raised in the POP
// state, and the word appears on locIn in the following cycle (LOAD), where
// it is registered into cur.
module path_decoder #(
    parameter int COORD_W   = 4,
    parameter int MAX_STEPS = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 empStck,
    input  logic [2*COORD_W-1:0] locIn,
    output logic                 pop,
    output logic [1:0]           dirOut,
    output logic                 dirValid,
    input  logic                 dirReady,
    output logic [7:0]           stepCnt,
    output logic                 finished,
    output logic                 err
);

    localparam int LOC_W = 2 * COORD_W;

    // Move codes as seen on dirOut.
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // Coordinates are compared one bit wider so that +1 at the grid edge
    // carries out instead of wrapping back to zero.
    localparam logic [COORD_W:0] ONE = (COORD_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        CHECK,
        EMIT,
        DONE,
        ERR
    } state_t;

    state_t             state;
    logic [LOC_W-1:0]   prev_loc;
    logic [LOC_W-1:0]   cur_loc;
    logic               first_seen;

    logic [COORD_W:0]   prev_x;
    logic [COORD_W:0]   prev_y;
    logic [COORD_W:0]   cur_x;
    logic [COORD_W:0]   cur_y;

    logic               x_same;
    logic               y_same;
    logic               x_inc;
    logic               x_dec;
    logic               y_inc;
    logic               y_dec;

    logic               step_ok;
    logic [1:0]         step_dir;
    logic               at_limit;

    // Split both locations into zero-extended X and Y coordinates.
    assign prev_x = {1'b0, prev_loc[LOC_W-1:COORD_W]};
    assign prev_y = {1'b0, prev_loc[COORD_W-1:0]};
    assign cur_x  = {1'b0, cur_loc[LOC_W-1:COORD_W]};
    assign cur_y  = {1'b0, cur_loc[COORD_W-1:0]};

    // Per-axis relations between the previous and the current location.
    assign x_same = (cur_x == prev_x);
    assign y_same = (cur_y == prev_y);
    assign x_inc  = (cur_x == prev_x + ONE);
    assign x_dec  = (cur_x + ONE == prev_x);
    assign y_inc  = (cur_y == prev_y + ONE);
    assign y_dec  = (cur_y + ONE == prev_y);

    // No room left for another move once the accepted count reaches the
    // limit; stepCnt is 8 bits, so MAX_STEPS above 255 cannot be honoured.
    assign at_limit = (int'(stepCnt) >= MAX_STEPS);

    // Classify the step prev -> cur: legal only when one axis is unchanged
    // and the other moves by exactly one; also pick the matching move code.
    always_comb begin
        step_ok  = 1'b0;
        step_dir = DIR_UP;
        if (x_same && y_dec) begin
            step_ok  = 1'b1;
            step_dir = DIR_UP;
        end else if (y_same && x_inc) begin
            step_ok  = 1'b1;
            step_dir = DIR_RIGHT;
        end else if (x_same && y_inc) begin
            step_ok  = 1'b1;
            step_dir = DIR_DOWN;
        end else if (y_same && x_dec) begin
            step_ok  = 1'b1;
            step_dir = DIR_LEFT;
        end
    end

    // Main controller. All outputs are registered here. pop is raised on the
    // edge that enters POP, using the store's empty flag at that edge, so it
    // is high for exactly the one cycle spent in POP; POP then follows pop:
    // a request was made -> LOAD, no request (store empty) -> DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pop        <= 1'b0;
            dirOut     <= DIR_UP;
            dirValid   <= 1'b0;
            stepCnt    <= 8'd0;
            finished   <= 1'b0;
            err        <= 1'b0;
            prev_loc   <= '0;
            cur_loc    <= '0;
            first_seen <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= POP;
                        pop        <= ~empStck;
                        stepCnt    <= 8'd0;
                        first_seen <= 1'b0;
                        finished   <= 1'b0;
                        err        <= 1'b0;
                    end
                end

                POP: begin
                    pop <= 1'b0;
                    if (pop) begin
                        state <= LOAD;
                    end else begin
                        state    <= DONE;
                        finished <= 1'b1;
                    end
                end

                LOAD: begin
                    cur_loc <= locIn;
                    state   <= CHECK;
                end

                CHECK: begin
                    if (!first_seen) begin
                        prev_loc   <= cur_loc;
                        first_seen <= 1'b1;
                        state      <= POP;
                        pop        <= ~empStck;
                    end else if (!step_ok || at_limit) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        dirOut   <= step_dir;
                        dirValid <= 1'b1;
                        prev_loc <= cur_loc;
                        state    <= EMIT;
                    end
                end

                EMIT: begin
                    if (dirValid && dirReady) begin
                        stepCnt  <= stepCnt + 8'd1;
                        dirValid <= 1'b0;
                        state    <= POP;
                        pop      <= ~empStck;
                    end
                end

                default: begin
                    state <= IDLE;
                    pop   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_decoder.sv
// Testbench for path_decoder: a queue-based model of the upstream path store,
// a reference model that derives the expected moves and outcome from the
// location list with plain coordinate arithmetic, directed cases for the
// listed scenarios, and a batch of random walks with occasional bad steps.
module tb_path_decoder;

    localparam int COORD_W   = 4;
    localparam int MAX_STEPS = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       empStck;
    logic [7:0] locIn;
    logic       pop;
    logic [1:0] dirOut;
    logic       dirValid;
    logic       dirReady;
    logic [7:0] stepCnt;
    logic       finished;
    logic       err;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] pathQ[$];
    logic [7:0] storeQ[$];
    logic [1:0] gotMoves[$];
    logic [1:0] expMoves[$];

    int         popCount;
    int         readyMode;
    int         waitCnt;
    int         lastEndCyc;
    bit         popSeen;
    bit         prevStall;
    logic [1:0] prevDir;

    int         expSteps;
    bit         expErr;
    int         expPops;

    path_decoder #(
        .COORD_W  (COORD_W),
        .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .empStck (empStck),
        .locIn   (locIn),
        .pop     (pop),
        .dirOut  (dirOut),
        .dirValid(dirValid),
        .dirReady(dirReady),
        .stepCnt (stepCnt),
        .finished(finished),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: walk the location list, stop at the first illegal or
    // over-limit step, and list the move codes that should come out.
    task automatic buildExpected();
        int dx;
        int dy;
        expMoves.delete();
        expErr   = 1'b0;
        expSteps = 0;
        expPops  = pathQ.size();
        for (int i = 1; i < pathQ.size(); i++) begin
            dx = int'(pathQ[i][7:4]) - int'(pathQ[i-1][7:4]);
            dy = int'(pathQ[i][3:0]) - int'(pathQ[i-1][3:0]);
            if ((dx * dx + dy * dy) != 1 || expSteps == MAX_STEPS) begin
                expErr  = 1'b1;
                expPops = i + 1;
                break;
            end
            if (dy == -1)      expMoves.push_back(2'b00);
            else if (dx == 1)  expMoves.push_back(2'b01);
            else if (dy == 1)  expMoves.push_back(2'b10);
            else               expMoves.push_back(2'b11);
            expSteps++;
        end
    endtask

    // Observe the DUT mid-cycle: invariants, handshake and pop bookkeeping.
    task automatic sampleNeg();
        @(negedge clk);
        checkOutput("pop_with_valid", 32'(pop && dirValid), 32'd0);
        checkOutput("finished_and_err", 32'(finished && err), 32'd0);
        if (prevStall) begin
            checkOutput("hold_valid", 32'(dirValid), 32'd1);
            checkOutput("hold_dir", 32'(dirOut), 32'(prevDir));
        end
        prevStall = dirValid && !dirReady;
        prevDir   = dirOut;
        popSeen   = pop;
        if (pop) popCount++;
        if (dirValid && dirReady) gotMoves.push_back(dirOut);
    endtask

    // Just after the edge: the store answers a pop, and dirReady is updated.
    task automatic driveAfterEdge();
        @(posedge clk);
        #1;
        if (popSeen && storeQ.size() > 0) locIn = storeQ.pop_front();
        empStck = (storeQ.size() == 0);
        case (readyMode)
            0: dirReady = 1'($urandom_range(0, 1));
            1: dirReady = 1'b1;
            2: begin
                if (dirValid) begin
                    dirReady = (waitCnt >= 5);
                    waitCnt++;
                end else begin
                    dirReady = 1'b0;
                    waitCnt  = 0;
                end
            end
            default: dirReady = 1'b0;
        endcase
    endtask

    // Load the store with pathQ and issue a one-cycle start pulse.
    task automatic applyStimulus(input int mode);
        storeQ    = pathQ;
        empStck   = (storeQ.size() == 0);
        readyMode = mode;
        waitCnt   = 0;
        dirReady  = (mode == 1);
        popCount  = 0;
        popSeen   = 1'b0;
        prevStall = 1'b0;
        gotMoves.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Decode pathQ end to end and compare everything against the model.
    task automatic runPath(input string name, input int mode);
        int n;
        buildExpected();
        applyStimulus(mode);
        lastEndCyc = 0;
        for (int c = 1; c <= 5000; c++) begin
            sampleNeg();
            if (finished || err) begin
                lastEndCyc = c;
                break;
            end
            driveAfterEdge();
        end
        checkOutput({name, "_ended"}, 32'(lastEndCyc != 0), 32'd1);
        checkOutput({name, "_err"}, 32'(err), 32'(expErr));
        checkOutput({name, "_finished"}, 32'(finished), 32'(!expErr));
        checkOutput({name, "_stepCnt"}, 32'(stepCnt), 32'(expSteps));
        checkOutput({name, "_pops"}, 32'(popCount), 32'(expPops));
        checkOutput({name, "_dirValid"}, 32'(dirValid), 32'd0);
        checkOutput({name, "_moveCount"}, 32'(gotMoves.size()), 32'(expMoves.size()));
        n = (gotMoves.size() < expMoves.size()) ? gotMoves.size() : expMoves.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({name, "_move"}, 32'(gotMoves[i]), 32'(expMoves[i]));
        end
    endtask

    // Random walk on the 16x16 grid; roughly one in eight steps jumps to an
    // arbitrary location, which the model may or may not accept.
    task automatic makeRandomPath();
        int len;
        int x;
        int y;
        int d;
        int nx;
        int ny;
        logic [7:0] loc;
        pathQ.delete();
        len = $urandom_range(0, 8);
        loc = 8'($urandom_range(0, 255));
        for (int i = 0; i < len; i++) begin
            pathQ.push_back(loc);
            if ($urandom_range(0, 7) == 0) begin
                loc = 8'($urandom_range(0, 255));
            end else begin
                x  = int'(loc[7:4]);
                y  = int'(loc[3:0]);
                nx = -1;
                ny = -1;
                while (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
                    d  = $urandom_range(0, 3);
                    nx = x + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
                    ny = y + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
                end
                loc = {4'(nx), 4'(ny)};
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        empStck  = 1'b1;
        dirReady = 1'b0;
        locIn    = 8'h00;
        readyMode = 3;
        popSeen   = 1'b0;
        prevStall = 1'b0;
        popCount  = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pop", 32'(pop), 32'd0);
        checkOutput("rst_dirValid", 32'(dirValid), 32'd0);
        checkOutput("rst_dirOut", 32'(dirOut), 32'd0);
        checkOutput("rst_stepCnt", 32'(stepCnt), 32'd0);
        checkOutput("rst_finished", 32'(finished), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Nothing happens without start, even with a non-empty store.
        empStck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sampleNeg();
            checkOutput("idle_pop", 32'(pop), 32'd0);
            checkOutput("idle_finished", 32'(finished), 32'd0);
            driveAfterEdge();
        end

        pathQ = '{8'h00, 8'h01, 8'h11, 8'h12};
        runPath("basic", 1);

        pathQ = '{8'h22, 8'h21, 8'h11};
        runPath("stall", 2);

        pathQ = '{8'hF0, 8'h00};
        runPath("nowrap", 1);

        pathQ = '{8'h33, 8'h33};
        runPath("repeat", 1);

        pathQ = '{8'h33, 8'h44};
        runPath("diag", 1);

        pathQ.delete();
        runPath("empty", 1);
        checkOutput("empty_latency", 32'(lastEndCyc), 32'd2);

        pathQ = '{8'h57};
        runPath("single", 0);

        // One move too many: 256 alternating steps against a limit of 255.
        pathQ.delete();
        for (int i = 0; i < 257; i++) pathQ.push_back((i % 2 == 0) ? 8'h00 : 8'h01);
        runPath("overflow", 1);

        // Reset while a move is waiting in EMIT, then recover.
        pathQ = '{8'h00, 8'h01};
        applyStimulus(3);
        for (int c = 0; c < 20; c++) begin
            sampleNeg();
            if (dirValid) break;
            driveAfterEdge();
        end
        checkOutput("emit_reached", 32'(dirValid), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_pop", 32'(pop), 32'd0);
        checkOutput("midrst_dirValid", 32'(dirValid), 32'd0);
        checkOutput("midrst_dirOut", 32'(dirOut), 32'd0);
        checkOutput("midrst_stepCnt", 32'(stepCnt), 32'd0);
        checkOutput("midrst_finished", 32'(finished), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pathQ = '{8'h10, 8'h00};
        runPath("recover", 1);

        for (int t = 0; t < 25; t++) begin
            makeRandomPath();
            runPath($sformatf("rand%0d", t), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/path_decoder.md
PATH_DECODER -- requirements
Module: path_decoder

Interface
REQ-001 The parameter COORD_W SHALL default to 4 and set the width of each coordinate; location width is 2*COORD_W, X in the upper half and Y in the lower half.
REQ-002 The parameter MAX_STEPS SHALL default to 255 and set the largest number of moves accepted before overflow error.
REQ-003 The port clk SHALL be an input, 1 bit, and the single clock; all state changes on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit, asynchronous active-high reset.
REQ-005 The port start SHALL be an input, 1 bit, one-cycle pulse that begins decoding of a stored path (issued after the storage stage enters queue mode).
REQ-006 The port empStck SHALL be an input, 1 bit, storage-empty flag from the upstream path store.
REQ-007 The port locIn SHALL be an input, 2*COORD_W bits, location word returned by the path store one cycle after a pop.
REQ-008 The port pop SHALL be an output, 1 bit, one-cycle read request to the path store.
REQ-009 The port dirOut SHALL be an output, 2 bits, move code: 00 Y-1 (up), 01 X+1 (right), 10 Y+1 (down), 11 X-1 (left).
REQ-010 The port dirValid SHALL be an output, 1 bit, dirOut holds a valid move.
REQ-011 The port dirReady SHALL be an input, 1 bit, downstream accepts dirOut.
REQ-012 The port stepCnt SHALL be an output, 8 bits, number of moves accepted downstream.
REQ-013 The port finished SHALL be an output, 1 bit, path fully decoded without error.
REQ-014 The port err SHALL be an output, 1 bit, non-adjacent step, repeated location, or step overflow detected.

Function
REQ-015 The FSM SHALL have states IDLE, POP, LOAD, CHECK, EMIT, DONE, ERR.
REQ-016 IDLE SHALL wait for start; on start, go to POP and clear stepCnt, the first-location flag, finished, and err.
REQ-017 POP SHALL go to DONE if empStck=1; otherwise it SHALL assert pop for exactly one cycle and go to LOAD.
REQ-018 LOAD SHALL wait one cycle, then register locIn as cur and go to CHECK.
REQ-019 CHECK with the first-location flag clear SHALL copy cur to prev, set the flag, emit no move, and return to POP.
REQ-020 CHECK otherwise SHALL compute the move from prev to cur: exactly one coordinate must differ by exactly 1, with no modulo wrap (15->0 is not adjacent).
REQ-021 In CHECK, an equal or non-adjacent location SHALL go to ERR.
REQ-022 In CHECK, a step that would exceed MAX_STEPS SHALL go to ERR.
REQ-023 In CHECK, a valid step SHALL load dirOut, set dirValid, copy cur to prev, and go to EMIT.
REQ-024 EMIT SHALL hold dirOut and dirValid stable until dirValid&&dirReady; on that cycle it SHALL increment stepCnt, drop dirValid next cycle, and go to POP.
REQ-025 pop SHALL never be asserted outside POP, and never while dirValid=1.
REQ-026 DONE SHALL set finished=1 and hold it.
REQ-027 ERR SHALL set err=1 and hold it.
REQ-028 From DONE or ERR, a new start SHALL restart at REQ-016.
REQ-029 start SHALL be ignored in all states other than IDLE, DONE, and ERR.
REQ-030 An empty path (empStck=1 at the first POP) SHALL reach DONE with stepCnt=0.
REQ-031 A single-location path SHALL reach DONE with stepCnt=0.
REQ-032 finished and err SHALL never be 1 simultaneously.

Reset
REQ-033 rst=1 SHALL immediately force the state to IDLE and set pop=0, dirValid=0, dirOut=00, stepCnt=0, finished=0, err=0, prev=0, cur=0, and the first-location flag clear, regardless of the current state, including mid-EMIT.
REQ-034 After rst deasserts, the block SHALL do nothing until the next start.

Verification
REQ-035 Path 0x00,0x01,0x11,0x12 with dirReady=1 -> moves 10,01,10; stepCnt=3; finished=1; err=0.
REQ-036 Path 0x22,0x21,0x11 with dirReady held low 5 cycles per move -> dirOut stable while valid; moves 00,11; one pop per move; stepCnt=2.
REQ-037 Path 0xF0,0x00 -> err=1 (no wrap); no dirValid pulse; finished=0.
REQ-038 Path 0x33,0x33 -> err=1; Path 0x33,0x44 -> err=1.
REQ-039 empStck=1 at start -> no pop; finished=1 two cycles after start; stepCnt=0.
REQ-040 rst pulse while dirValid=1 in EMIT -> all outputs 0 immediately; a following start on path 0x10,0x00 -> move 11, stepCnt=1.
